// File: rtl/sklansky_pkg.sv
// Shared constants, stage control type and elaboration helpers for the
// pipelined exact/approximate Sklansky adder.
package sklansky_pkg;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;

  // Per-transaction control carried alongside the g/p vectors of stage 1.
  typedef struct packed {
    logic mode;
    logic cin;
  } stage_ctl_t;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sklansky_prefix_tree.sv
// Combinational Sklansky generate/propagate prefix over bits LO..WIDTH;
// carry[i] is the carry out of bit i with cin entering below bit LO.
module sklansky_prefix_tree
  import sklansky_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LO    = 1
) (
  input  logic [WIDTH:LO] g,
  input  logic [WIDTH:LO] p,
  input  logic            cin,
  output logic [WIDTH:LO] carry
);

  localparam int N      = WIDTH - LO + 1;
  localparam int LEVELS = clog2(N);

  logic [N-1:0] gg_s;
  logic [N-1:0] pp_s;

  // Each level merges the upper half of every 2^(l+1) block with the top of its lower half.
  always_comb begin
    gg_s    = g;
    pp_s    = p;
    gg_s[0] = g[LO] | (p[LO] & cin);
    for (int l = 0; l < LEVELS; l++) begin
      for (int j = N - 1; j >= 0; j--) begin
        if (((j >> l) & 1) == 1) begin
          gg_s[j] = gg_s[j] | (pp_s[j] & gg_s[((j >> l) << l) - 1]);
          pp_s[j] = pp_s[j] & pp_s[((j >> l) << l) - 1];
        end else begin
          gg_s[j] = gg_s[j];
          pp_s[j] = pp_s[j];
        end
      end
    end
  end

  assign carry = gg_s;

endmodule

// File: rtl/sklansky_approx_pipe.sv
// Three-stage valid/ready Sklansky adder with a per-transaction exact or
// approximate (OR-based lower K bits) mode.
module sklansky_approx_pipe
  import sklansky_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int K     = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           In_Valid,
  output logic           In_Ready,
  input  logic           Mode,
  input  logic [WIDTH:1] A,
  input  logic [WIDTH:1] B,
  input  logic           Cin,
  output logic           Out_Valid,
  input  logic           Out_Ready,
  output logic [WIDTH:1] Sum,
  output logic [WIDTH:0] Cout,
  output logic           Out_Mode
);

  typedef struct packed {
    stage_ctl_t     ctl;
    logic [WIDTH:1] g;
    logic [WIDTH:1] p;
  } payload_t;

  payload_t       in_payload_s;
  payload_t       s1_r;
  logic           s1_valid_r;
  logic           s2_valid_r;
  logic           s2_mode_r;
  logic [WIDTH:1] s2_half_r;
  logic [WIDTH:0] s2_carry_r;

  logic           s1_load_s;
  logic           s2_load_s;
  logic           s3_load_s;

  logic [WIDTH:1] tree_g_s;
  logic [WIDTH:1] tree_p_s;
  logic           tree_cin_s;
  logic [WIDTH:1] tree_carry_s;
  logic [WIDTH:1] half_s;

  // A stage may load when it is empty or its content moves on this cycle.
  assign s3_load_s = !Out_Valid || Out_Ready;
  assign s2_load_s = !s2_valid_r || s3_load_s;
  assign s1_load_s = !s1_valid_r || s2_load_s;
  assign In_Ready  = s1_load_s;

  assign in_payload_s = {Mode, Cin, A & B, A ^ B};

  // Stage valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
      Out_Valid  <= 1'b0;
    end else begin
      if (s1_load_s) s1_valid_r <= In_Valid;
      if (s2_load_s) s2_valid_r <= s1_valid_r;
      if (s3_load_s) Out_Valid  <= s2_valid_r;
    end
  end

  // Stage 1: operand capture as bitwise generate/propagate.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r <= '0;
    end else if (s1_load_s && In_Valid) begin
      s1_r <= in_payload_s;
    end
  end

  // Approximate mode kills the low carry chain except for the single g[K] carry.
  always_comb begin
    tree_g_s   = s1_r.g;
    tree_p_s   = s1_r.p;
    half_s     = s1_r.p;
    tree_cin_s = s1_r.ctl.cin;
    if (s1_r.ctl.mode == MODE_APPROX) begin
      tree_cin_s = 1'b0;
      for (int i = 1; i <= K; i++) begin
        tree_g_s[i] = (i == K) ? s1_r.g[i] : 1'b0;
        tree_p_s[i] = 1'b0;
        half_s[i]   = s1_r.g[i] | s1_r.p[i];
      end
    end else begin
      tree_cin_s = s1_r.ctl.cin;
    end
  end

  sklansky_prefix_tree #(
    .WIDTH (WIDTH),
    .LO    (1)
  ) u_tree (
    .g     (tree_g_s),
    .p     (tree_p_s),
    .cin   (tree_cin_s),
    .carry (tree_carry_s)
  );

  // Stage 2: carry vector and per-bit half sums.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_mode_r  <= 1'b0;
      s2_half_r  <= '0;
      s2_carry_r <= '0;
    end else if (s2_load_s && s1_valid_r) begin
      s2_mode_r  <= s1_r.ctl.mode;
      s2_half_r  <= half_s;
      s2_carry_r <= {tree_carry_s, tree_cin_s};
    end
  end

  // Stage 3: registered outputs, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      Sum      <= '0;
      Cout     <= '0;
      Out_Mode <= 1'b0;
    end else if (s3_load_s && s2_valid_r) begin
      Sum      <= s2_half_r ^ s2_carry_r[WIDTH-1:0];
      Cout     <= s2_carry_r;
      Out_Mode <= s2_mode_r;
    end
  end

endmodule

// File: tb/tb_sklansky_approx_pipe.sv
// Self-checking bench: directed table, random stream against an arithmetic
// reference model, stall and mid-flight reset sequences.
module tb_sklansky_approx_pipe;

  localparam int W = 16;
  localparam int K = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         In_Valid;
  logic         In_Ready;
  logic         Mode;
  logic [W:1]   A;
  logic [W:1]   B;
  logic         Cin;
  logic         Out_Valid;
  logic         Out_Ready;
  logic [W:1]   Sum;
  logic [W:0]   Cout;
  logic         Out_Mode;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       mode;
    logic [W:1] sum;
    logic [W:0] cout;
    logic [W:0] mask;
  } exp_t;

  typedef struct {
    logic       mode;
    logic [W:1] a;
    logic [W:1] b;
    logic       cin;
    logic [W:1] sum;
    logic [W:0] cout;
    logic [W:0] mask;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  exp_t first_e;
  exp_t tmp_e;
  vec_t vecs[6];
  bit   rand_done;
  int   lat;

  sklansky_approx_pipe #(.WIDTH(W), .K(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .Mode      (Mode),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Sum       (Sum),
    .Cout      (Cout),
    .Out_Mode  (Out_Mode)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic m, input logic [W:1] a, input logic [W:1] b, input logic c);
    exp_t        e;
    logic [63:0] ua, ub, mk, t, cy;
    ua = 64'(a);
    ub = 64'(b);
    e.mode = m;
    e.mask = '1;
    e.cout = '0;
    if (m == 1'b0) begin
      t = ua + ub + 64'(c);
      e.sum = t[W-1:0];
      e.cout[0] = c;
      for (int i = 1; i <= W; i++) begin
        mk = (64'd1 << i) - 64'd1;
        t  = (ua & mk) + (ub & mk) + 64'(c);
        e.cout[i] = t[i];
      end
    end else begin
      cy = 64'(a[K] & b[K]);
      ua = ua >> K;
      ub = ub >> K;
      t  = ((ua + ub + cy) << K) | (64'(a | b) & ((64'd1 << K) - 64'd1));
      e.sum = t[W-1:0];
      e.cout[K] = cy[0];
      for (int i = 1; i <= W - K; i++) begin
        mk = (64'd1 << i) - 64'd1;
        t  = (ua & mk) + (ub & mk) + cy;
        e.cout[K+i] = t[i];
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic send(input logic m, input logic [W:1] a, input logic [W:1] b, input logic c, input exp_t e);
    int waited;
    waited   = 0;
    In_Valid = 1'b1;
    Mode     = m;
    A        = a;
    B        = b;
    Cin      = c;
    @(negedge clk);
    while (In_Ready !== 1'b1 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (In_Ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: In_Ready=%b after %0d cycles, expected 1", In_Ready, waited);
    end else begin
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    In_Valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
    end
  endtask

  // Scoreboard: every delivered result must match the oldest accepted transaction.
  always @(negedge clk) begin
    if (rst !== 1'b1 && Out_Valid === 1'b1 && Out_Ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got sum=%h cout=%h mode=%b, expected no output", Sum, Cout, Out_Mode);
      end else begin
        mon_e = exp_q.pop_front();
        if (Sum !== mon_e.sum || ((Cout ^ mon_e.cout) & mon_e.mask) !== '0 || Out_Mode !== mon_e.mode) begin
          errors++;
          $display("FAIL result: got sum=%h cout=%h mode=%b, expected sum=%h cout=%h (mask %h) mode=%b",
                   Sum, Cout, Out_Mode, mon_e.sum, mon_e.cout, mon_e.mask, mon_e.mode);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 16'hAAEA, 16'h4D55, 1'b0, 16'hF83F, 17'h00000, 17'h10000};
    vecs[1] = '{1'b1, 16'hAAEA, 16'h4D55, 1'b0, 16'hF7FF, 17'h00000, 17'h10100};
    vecs[2] = '{1'b0, 16'hF0F0, 16'h0F0F, 1'b1, 16'h0000, 17'h10000, 17'h10000};
    vecs[3] = '{1'b1, 16'hF0F0, 16'h0F0F, 1'b1, 16'hFFFF, 17'h00000, 17'h10000};
    vecs[4] = '{1'b1, 16'hFFFF, 16'h4490, 1'b1, 16'h44FF, 17'h10100, 17'h10100};
    vecs[5] = '{1'b0, 16'hFFFF, 16'h4490, 1'b1, 16'h4490, 17'h10000, 17'h10000};

    rst = 1'b1; In_Valid = 1'b0; Mode = 1'b0; A = '0; B = '0; Cin = 1'b0; Out_Ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_out_valid", 32'(Out_Valid), 32'd0);
    chk("reset_sum",       32'(Sum),       32'd0);
    chk("reset_cout",      32'(Cout),      32'd0);
    chk("reset_out_mode",  32'(Out_Mode),  32'd0);
    chk("reset_in_ready",  32'(In_Ready),  32'd1);

    // Directed vectors, streamed back to back.
    for (int i = 0; i < 6; i++) begin
      tmp_e.mode = vecs[i].mode;
      tmp_e.sum  = vecs[i].sum;
      tmp_e.cout = vecs[i].cout;
      tmp_e.mask = vecs[i].mask;
      send(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].cin, tmp_e);
    end
    drain();

    // Alternating modes with a 5-cycle output stall after the first result.
    fork
      begin
        for (int n = 0; n < 4; n++) begin
          logic [W:1] ra;
          logic [W:1] rb;
          logic       rc;
          ra = W'($urandom);
          rb = W'($urandom);
          rc = 1'($urandom_range(0, 1));
          send(1'(n % 2), ra, rb, rc, model(1'(n % 2), ra, rb, rc));
        end
      end
      begin
        int w;
        w = 0;
        do begin
          @(posedge clk);
          #1;
          w++;
        end while (Out_Valid !== 1'b1 && w < 20);
        Out_Ready = 1'b0;
        #1;
        first_e = exp_q[0];
        for (int k = 0; k < 5; k++) begin
          if (k > 0) begin
            @(posedge clk);
            #1;
          end
          chk("stall_out_valid", 32'(Out_Valid), 32'd1);
          chk("stall_sum",       32'(Sum),       32'(first_e.sum));
          chk("stall_cout",      32'(Cout),      32'(first_e.cout));
          chk("stall_out_mode",  32'(Out_Mode),  32'(first_e.mode));
          chk("stall_in_ready",  32'(In_Ready),  32'd0);
        end
        Out_Ready = 1'b1;
      end
    join
    drain();

    // Random stream with input gaps and output back-pressure.
    rand_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          logic       rm;
          logic [W:1] ra;
          logic [W:1] rb;
          logic       rc;
          rm = 1'($urandom_range(0, 1));
          ra = (n % 16 == 0) ? '1 : W'($urandom);
          rb = W'($urandom);
          rc = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
          end
          send(rm, ra, rb, rc, model(rm, ra, rb, rc));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          Out_Ready = ($urandom_range(0, 3) != 0);
        end
        Out_Ready = 1'b1;
      end
    join
    drain();

    // Reset with three transactions in flight and In_Valid asserted during reset.
    for (int n = 0; n < 3; n++) begin
      send(1'(n % 2), 16'h1357 + 16'(n), 16'hF00D, 1'b1, model(1'(n % 2), 16'h1357 + 16'(n), 16'hF00D, 1'b1));
    end
    rst = 1'b1; In_Valid = 1'b1; Mode = 1'b0; A = 16'h1234; B = 16'h1111; Cin = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    In_Valid = 1'b0;
    exp_q.delete();
    chk("mid_rst_out_valid", 32'(Out_Valid), 32'd0);
    chk("mid_rst_sum",       32'(Sum),       32'd0);
    chk("mid_rst_cout",      32'(Cout),      32'd0);
    chk("mid_rst_out_mode",  32'(Out_Mode),  32'd0);
    chk("mid_rst_in_ready",  32'(In_Ready),  32'd1);
    repeat (6) begin
      @(posedge clk);
      #1;
      chk("post_rst_quiet", 32'(Out_Valid), 32'd0);
    end
    send(1'b1, 16'hFFFF, 16'h4490, 1'b1, model(1'b1, 16'hFFFF, 16'h4490, 1'b1));
    lat = 1;
    while (Out_Valid !== 1'b1 && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("post_rst_latency", 32'(lat), 32'd3);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
